decode_in_capture_fifo: RTL and testbench
=========================================

// Module: decode_in_capture_fifo
// PURPOSE
//  Synthesizable, parametrised capture unit for the decode-stage input bus (instr_dout, npc_in, Sr, en_decode).
//  After a post-reset settle window it samples the bus every clock, filters samples by mode, and tags each with a sequence number.
//  Accepted samples go into a first-word-fall-through FIFO, which drains over a valid/ready handshake to a checker or scoreboard.
//  It sits beside the decode stage, in the bench or in an on-chip trace path.
// PARAMETERS
//  INSTR_W       16  width of instr_dout / txn_instr
//  NPC_W         16  width of npc_in / txn_npc
//  SR_W          3   width of Sr / txn_sr
//  DEPTH         8   FIFO entries; power of 2, >=2
//  SETTLE_CYCLES 7   clocks after reset deassertion before capture starts; 0 = capture on first clock after reset
//  MODE          0   0 = every cycle; 1 = only when en_decode=1; 2 = only when {instr,npc,sr,en} differs from last qualified sample
//  SEQ_W         16  sequence-number width
// PORTS
//  clock         in   1        single clock; everything on posedge
//  reset         in   1        synchronous, active-high
//  instr_dout    in   INSTR_W  instruction word to decode
//  npc_in        in   NPC_W    next PC
//  Sr            in   SR_W     status register (NZP)
//  en_decode     in   1        decode enable
//  capture_en    in   1        0 = samples are ignored (no seq increment); FIFO still drains
//  armed         out  1        1 while in ARMED state
//  txn_valid     out  1        FIFO head valid
//  txn_ready     in   1        consumer accepts head
//  txn_instr     out  INSTR_W  head: instr_dout
//  txn_npc       out  NPC_W    head: npc_in
//  txn_sr        out  SR_W     head: Sr
//  txn_en        out  1        head: en_decode
//  txn_seq       out  SEQ_W    head: sequence number
//  count         out  $clog2(DEPTH)+1  FIFO occupancy
//  overflow_cnt  out  16       dropped samples, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (any cycle, including mid-operation):
//   - FIFO is flushed; count=0, txn_valid=0.
//   - txn_* data outputs are 0; overflow_cnt=0; seq=0; armed=0.
//   - The last-sample register is cleared and marked invalid.
//   - State goes to SETTLE with settle counter=0.
//  FSM:
//   - SETTLE: the counter increments each clock with reset=0.
//   - SETTLE -> ARMED on the edge where counter==SETTLE_CYCLES-1.
//   - With SETTLE_CYCLES=0, the FSM goes straight to ARMED on the first clock after reset.
//   - ARMED stays until reset.
//   - No bus sampling in SETTLE.
//  Sample qualification (ARMED, capture_en=1, at the posedge): MODE0 always; MODE1 en_decode==1; MODE2 last invalid OR any field differs from last.
//  Each qualified sample:
//   - Tagged with the current seq; seq then increments mod 2^SEQ_W.
//   - The last-sample register is updated, MODE2 only.
//   - Seq increments even if the sample is dropped, so consumer-visible seq gaps mark drops.
//  Push: a qualified sample is written if count<DEPTH, or if count==DEPTH and a pop happens on the same edge; otherwise it is dropped and overflow_cnt increments (saturating).
//  Pop: on an edge with txn_valid && txn_ready. txn_ready with txn_valid=0 has no effect.
//  Simultaneous push+pop: count is unchanged; push data enters at the tail.
//  FWFT latency: a sample taken at edge N into an empty FIFO gives txn_valid=1 after edge N, with its fields on txn_*. No combinational path from bus inputs to txn_*.
//  txn_* stay stable while txn_valid && !txn_ready.
//  Field mapping is fixed: txn_instr<-instr_dout, txn_npc<-npc_in, txn_sr<-Sr, txn_en<-en_decode. Never swapped.
//  Pointers wrap modulo DEPTH; count is the exact occupancy 0..DEPTH.
// TESTING
//  - reset 3 clk then release, MODE0, SETTLE=7: armed rises after 7th edge; first txn_seq=0 carries the bus value at edge 8.
//  - MODE1: en_decode pattern 1,0,1,1, instr 3000,3001,3002,3003 -> txns 3000,3002,3003 with seq 0,1,2.
//  - MODE2: bus held constant 5 clk, then npc 3001->3002 -> exactly 2 txns.
//  - DEPTH=8, txn_ready=0, 10 qualified samples: count=8, overflow_cnt=2; drain shows seq 0..7. The next sample has seq 10.
//  - Full FIFO with txn_ready=1 and a qualified sample on the same edge: count stays 8, overflow_cnt unchanged.
//  - Reset asserted mid-stream with count=5: next cycle txn_valid=0, count=0; armed re-rises after SETTLE_CYCLES; seq restarts at 0.

Source files
------------

// File: rtl/decode_in_capture_fifo.sv
// Capture unit for the decode-stage input bus. After a settle window it filters and
// sequence-tags bus samples into a first-word-fall-through FIFO drained by valid/ready.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_SETTLE | post-reset wait, settle counter running, bus not sampled
// ST_ARMED  | bus sampled every clock subject to capture_en and MODE
module decode_in_capture_fifo #(
  parameter int INSTR_W       = 16,
  parameter int NPC_W         = 16,
  parameter int SR_W          = 3,
  parameter int DEPTH         = 8,
  parameter int SETTLE_CYCLES = 7,
  parameter int MODE          = 0,
  parameter int SEQ_W         = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [INSTR_W-1:0]       instr_dout,
  input  logic [NPC_W-1:0]         npc_in,
  input  logic [SR_W-1:0]          Sr,
  input  logic                     en_decode,
  input  logic                     capture_en,
  output logic                     armed,
  output logic                     txn_valid,
  input  logic                     txn_ready,
  output logic [INSTR_W-1:0]       txn_instr,
  output logic [NPC_W-1:0]         txn_npc,
  output logic [SR_W-1:0]          txn_sr,
  output logic                     txn_en,
  output logic [SEQ_W-1:0]         txn_seq,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              overflow_cnt
);

  localparam int  AW          = $clog2(DEPTH);
  localparam int  CW          = AW + 1;
  localparam int  SCW         = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int  BUS_W       = INSTR_W + NPC_W + SR_W + 1;
  localparam int  ENT_W       = BUS_W + SEQ_W;
  localparam bit  SETTLE_NONE = (SETTLE_CYCLES == 0);

  typedef enum logic {ST_SETTLE, ST_ARMED} state_t;

  state_t             state;
  logic [SCW-1:0]     settle_cnt;
  logic               settle_done;
  logic [SEQ_W-1:0]   seq;
  logic [BUS_W-1:0]   bus;
  logic [BUS_W-1:0]   last_bus;
  logic               last_valid;
  logic [ENT_W-1:0]   mem [DEPTH];
  logic [ENT_W-1:0]   head;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count_q;
  logic               full;
  logic               qual;
  logic               push;
  logic               pop;

  assign bus         = {instr_dout, npc_in, Sr, en_decode};
  assign settle_done = SETTLE_NONE || (int'(settle_cnt) == SETTLE_CYCLES - 1);
  assign full        = (count_q == CW'(DEPTH));
  assign txn_valid   = (count_q != '0);
  assign pop         = txn_valid && txn_ready;
  // a full FIFO still accepts when the head leaves on the same edge
  assign push        = qual && (!full || pop);
  assign armed       = (state == ST_ARMED);
  assign count       = count_q;

  always_comb begin
    qual = 1'b0;
    if (state == ST_ARMED && capture_en) begin
      case (MODE)
        1:       qual = en_decode;
        2:       qual = !last_valid || (bus != last_bus);
        default: qual = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_SETTLE;
      settle_cnt   <= '0;
      seq          <= '0;
      last_valid   <= 1'b0;
      last_bus     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      overflow_cnt <= '0;
    end else begin
      case (state)
        ST_SETTLE: begin
          if (settle_done) state <= ST_ARMED;
          else             settle_cnt <= settle_cnt + 1'b1;
        end
        default: state <= ST_ARMED;
      endcase

      // seq advances on every qualified sample, so dropped samples leave gaps
      if (qual) begin
        seq <= seq + 1'b1;
        if (MODE == 2) begin
          last_valid <= 1'b1;
          last_bus   <= bus;
        end
        if (!push && overflow_cnt != 16'hFFFF)
          overflow_cnt <= overflow_cnt + 1'b1;
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {bus, seq};
  end

  // stale storage is hidden while empty so txn_* read as zero
  assign head = txn_valid ? mem[rd_ptr] : '0;
  assign {txn_instr, txn_npc, txn_sr, txn_en, txn_seq} = head;

endmodule

// File: tb/tb_decode_in_capture_fifo.sv
// Bench for decode_in_capture_fifo: three instances (MODE 0/1/2) on a shared bus,
// queue-based reference model feeding a scoreboard monitor.
module tb_decode_in_capture_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] instr, npc;
  logic [2:0]  sr;
  logic        en, cap;
  logic [2:0]  rdy;

  logic [2:0]  armed, tv, ten;
  logic [15:0] ti [3];
  logic [15:0] tn [3];
  logic [15:0] tseq [3];
  logic [2:0]  tsr [3];
  logic [15:0] ovf [3];
  logic [3:0]  cnt0, cnt2;
  logic [2:0]  cnt1;
  int          dut_cnt [3];

  always_comb begin
    dut_cnt[0] = int'(cnt0);
    dut_cnt[1] = int'(cnt1);
    dut_cnt[2] = int'(cnt2);
  end

  decode_in_capture_fifo #(.DEPTH(8), .SETTLE_CYCLES(7), .MODE(0)) u0 (
    .clock(clk), .reset(reset), .instr_dout(instr), .npc_in(npc), .Sr(sr),
    .en_decode(en), .capture_en(cap), .armed(armed[0]), .txn_valid(tv[0]),
    .txn_ready(rdy[0]), .txn_instr(ti[0]), .txn_npc(tn[0]), .txn_sr(tsr[0]),
    .txn_en(ten[0]), .txn_seq(tseq[0]), .count(cnt0), .overflow_cnt(ovf[0]));

  decode_in_capture_fifo #(.DEPTH(4), .SETTLE_CYCLES(7), .MODE(1)) u1 (
    .clock(clk), .reset(reset), .instr_dout(instr), .npc_in(npc), .Sr(sr),
    .en_decode(en), .capture_en(cap), .armed(armed[1]), .txn_valid(tv[1]),
    .txn_ready(rdy[1]), .txn_instr(ti[1]), .txn_npc(tn[1]), .txn_sr(tsr[1]),
    .txn_en(ten[1]), .txn_seq(tseq[1]), .count(cnt1), .overflow_cnt(ovf[1]));

  decode_in_capture_fifo #(.DEPTH(8), .SETTLE_CYCLES(0), .MODE(2)) u2 (
    .clock(clk), .reset(reset), .instr_dout(instr), .npc_in(npc), .Sr(sr),
    .en_decode(en), .capture_en(cap), .armed(armed[2]), .txn_valid(tv[2]),
    .txn_ready(rdy[2]), .txn_instr(ti[2]), .txn_npc(tn[2]), .txn_sr(tsr[2]),
    .txn_en(ten[2]), .txn_seq(tseq[2]), .count(cnt2), .overflow_cnt(ovf[2]));

  function automatic int depth_of(int i);
    return (i == 1) ? 4 : 8;
  endfunction
  function automatic int settle_of(int i);
    return (i == 2) ? 0 : 7;
  endfunction

  // reference model: occupancy, drop counter, seq and expected-entry queue per instance
  int          m_count [3];
  int          m_ovf [3];
  int          m_seq [3];
  int          m_edges [3];
  bit          m_armed [3];
  bit          m_lv [3];
  logic [35:0] m_last [3];
  logic [51:0] exq [3][1024];
  int          tl [3];
  bit          started = 1'b0;
  bit          mp, mq;
  logic [35:0] bus_now;

  always @(posedge clk) begin
    bus_now = {instr, npc, sr, en};
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_count[i] = 0; m_ovf[i] = 0; m_seq[i] = 0; m_edges[i] = 0;
        m_armed[i] = 1'b0; m_lv[i] = 1'b0; m_last[i] = '0;
        started = 1'b1;
      end else begin
        mp = (m_count[i] > 0) && rdy[i];
        mq = 1'b0;
        if (m_armed[i] && cap) begin
          if (i == 0)      mq = 1'b1;
          else if (i == 1) mq = en;
          else             mq = !m_lv[i] || (bus_now != m_last[i]);
        end
        if (mq) begin
          if (i == 2) begin
            m_lv[i] = 1'b1;
            m_last[i] = bus_now;
          end
          if (m_count[i] < depth_of(i) || mp) begin
            exq[i][tl[i] % 1024] = {bus_now, 16'(m_seq[i])};
            tl[i] = tl[i] + 1;
            m_count[i] = m_count[i] + 1;
          end else if (m_ovf[i] < 65535) begin
            m_ovf[i] = m_ovf[i] + 1;
          end
          m_seq[i] = (m_seq[i] + 1) % 65536;
        end
        if (mp) m_count[i] = m_count[i] - 1;
        m_edges[i] = m_edges[i] + 1;
        m_armed[i] = (m_edges[i] >= settle_of(i));
      end
    end
  end

  // monitor / scoreboard
  int          n_chk = 0;
  int          n_err = 0;
  int          hd [3];
  int          pops [3];
  int          dir_req_n = 0, dir_done_n = 0;
  int          dir_kind, dir_inst, dir_exp;
  logic [51:0] e;
  int          act;
  string       nm;

  task automatic chk(string name, int i, int a, int x);
    n_chk = n_chk + 1;
    if (a != x) begin
      n_err = n_err + 1;
      $display("FAIL %s inst%0d: got %0d expected %0d (t=%0t)", name, i, a, x, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        chk("txn_valid", i, int'(tv[i]), (m_count[i] > 0) ? 1 : 0);
        chk("count", i, dut_cnt[i], m_count[i]);
        chk("overflow_cnt", i, int'(ovf[i]), m_ovf[i]);
        chk("armed", i, int'(armed[i]), int'(m_armed[i]));
        if (reset) begin
          hd[i] = tl[i];
        end else if (tv[i] && rdy[i]) begin
          if (hd[i] == tl[i]) begin
            chk("pop_without_expected_entry", i, 1, 0);
          end else begin
            e = exq[i][hd[i] % 1024];
            chk("txn_instr", i, int'(ti[i]), int'(e[51:36]));
            chk("txn_npc", i, int'(tn[i]), int'(e[35:20]));
            chk("txn_sr", i, int'(tsr[i]), int'(e[19:17]));
            chk("txn_en", i, int'(ten[i]), int'(e[16]));
            chk("txn_seq", i, int'(tseq[i]), int'(e[15:0]));
            hd[i] = hd[i] + 1;
            pops[i] = pops[i] + 1;
          end
        end
      end
      if (dir_req_n != dir_done_n) begin
        case (dir_kind)
          0:       begin nm = "dir_count";    act = dut_cnt[dir_inst]; end
          1:       begin nm = "dir_overflow"; act = int'(ovf[dir_inst]); end
          2:       begin nm = "dir_valid";    act = int'(tv[dir_inst]); end
          3:       begin nm = "dir_head_seq"; act = int'(tseq[dir_inst]); end
          4:       begin nm = "dir_armed";    act = int'(armed[dir_inst]); end
          default: begin nm = "dir_txn_total"; act = pops[dir_inst]; end
        endcase
        chk(nm, dir_inst, act, dir_exp);
        dir_done_n = dir_req_n;
      end
    end
  end

  // stimulus
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic dir(int kind, int inst, int x);
    dir_kind = kind;
    dir_inst = inst;
    dir_exp  = x;
    dir_req_n = dir_req_n + 1;
  endtask

  task automatic rand_bus();
    instr = 16'($urandom);
    npc   = 16'($urandom);
    sr    = 3'($urandom);
    en    = 1'($urandom);
  endtask

  int base;
  bit en_pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    reset = 1'b1; cap = 1'b0; rdy = 3'b000;
    instr = '0; npc = '0; sr = '0; en = 1'b0;
    repeat (3) step();
    reset = 1'b0; cap = 1'b1; rand_bus();

    // settle window, then 10 samples into a depth-8 FIFO with no consumer
    repeat (6) begin step(); rand_bus(); end
    dir(4, 0, 0);
    step(); rand_bus();
    dir(4, 0, 1);
    repeat (10) begin step(); rand_bus(); end
    cap = 1'b0;
    dir(0, 0, 8);
    step();
    dir(1, 0, 2);

    rdy = 3'b111;
    repeat (12) step();
    rdy = 3'b000; cap = 1'b1; rand_bus();
    step();
    cap = 1'b0;
    dir(3, 0, 10);
    step();
    dir(2, 0, 1);

    // fill to 8, then push and pop on the same edge
    cap = 1'b1;
    repeat (7) begin rand_bus(); step(); end
    rdy = 3'b001; rand_bus();
    step();
    cap = 1'b0; rdy = 3'b000;
    dir(0, 0, 8);
    step();
    dir(1, 0, 2);
    rdy = 3'b111;
    repeat (12) step();

    // MODE1 en_decode filter
    base = pops[1];
    cap = 1'b1;
    for (int k = 0; k < 4; k++) begin
      instr = 16'(3000 + k);
      en = en_pat[k];
      step();
    end
    cap = 1'b0;
    repeat (3) step();
    dir(5, 1, base + 3);

    // MODE2 change filter: constant bus, then a single npc change
    step();
    base = pops[2];
    cap = 1'b1; instr = 16'h1234; npc = 16'd3001; sr = 3'd2; en = 1'b1;
    repeat (5) step();
    npc = 16'd3002;
    repeat (3) step();
    cap = 1'b0;
    repeat (3) step();
    dir(5, 2, base + 2);
    step();

    // randomized traffic with a narrow value range so MODE2 sees repeats
    for (int k = 0; k < 400; k++) begin
      instr = 16'($urandom_range(0, 2));
      npc   = 16'($urandom_range(0, 2));
      sr    = 3'($urandom_range(0, 1));
      en    = 1'($urandom);
      cap   = ($urandom_range(0, 4) != 0);
      rdy   = 3'($urandom);
      step();
    end

    // reset in mid-stream with five entries queued
    cap = 1'b0; rdy = 3'b111;
    repeat (12) step();
    rdy = 3'b000; cap = 1'b1;
    repeat (5) begin rand_bus(); step(); end
    dir(0, 0, 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    dir(2, 0, 0);
    step();
    dir(0, 0, 0);
    repeat (5) step();
    dir(4, 0, 0);
    step();
    dir(4, 0, 1);
    rand_bus();
    step();
    dir(3, 0, 0);
    for (int k = 0; k < 30; k++) begin
      rand_bus();
      rdy = 3'($urandom);
      step();
    end
    cap = 1'b0; rdy = 3'b111;
    repeat (12) step();

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
